// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU with start/busy/done handshake.
// Optional single-edge completion of trivial divides when DIV_FAST_PATH_EN is defined.
module div_seq_ctrl #(
  parameter int WIDTH           = 32,
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_flag,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             stall
);

  localparam int STEPS = WIDTH / ITERS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Handshake: start is accepted only in IDLE without flush; done is a single-cycle
  // pulse and q/r hold from that cycle until the next done.
  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_sign_q;
  logic             w_sign_r;
  logic             w_b_zero;
  logic             w_accept;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_q;
  logic [WIDTH-1:0] w_fast_r;
  logic [WIDTH:0]   w_rem_s;
  logic [WIDTH-1:0] w_quo_s;

  assign w_a_neg  = sign_flag & a[WIDTH-1];
  assign w_b_neg  = sign_flag & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_sign_q = sign_flag & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_sign_r = w_a_neg;
  assign w_b_zero = (b == '0);
  assign w_accept = (r_state == S_IDLE) && start && !flush;

`ifdef DIV_FAST_PATH_EN
  logic w_fast_small;
  logic w_fast_one;
  assign w_fast_small = (w_a_mag < w_b_mag);
  assign w_fast_one   = (w_b_mag == WIDTH'(1));
  assign w_fast       = !w_b_zero && (w_fast_small || w_fast_one);
  // |a|<|b| wins when both hold (only a==0), giving q=0, r=0 either way.
  assign w_fast_q     = w_fast_small ? '0 : (w_sign_q ? -w_a_mag : w_a_mag);
  assign w_fast_r     = w_fast_small ? a : '0;
`else
  assign w_fast   = 1'b0;
  assign w_fast_q = '0;
  assign w_fast_r = '0;
`endif

  // ITERS_PER_CYCLE restoring steps; the dividend shifts out of r_quo as quotient bits shift in.
  always_comb begin
    w_rem_s = r_rem;
    w_quo_s = r_quo;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      w_rem_s = {w_rem_s[WIDTH-1:0], w_quo_s[WIDTH-1]};
      w_quo_s = {w_quo_s[WIDTH-2:0], 1'b0};
      if (w_rem_s >= {1'b0, r_dvs}) begin
        w_rem_s    = w_rem_s - {1'b0, r_dvs};
        w_quo_s[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_b_zero && !w_fast) begin
          w_state_n = S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          w_state_n = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_state_n = S_FIX;
        end
      end
      S_FIX: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_done   <= 1'b0;
      r_q      <= '0;
      r_r      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_b_zero) begin
              r_q    <= '0;
              r_r    <= '0;
              r_done <= 1'b1;
            end else if (w_fast) begin
              r_q    <= w_fast_q;
              r_r    <= w_fast_r;
              r_done <= 1'b1;
            end else begin
              r_rem    <= '0;
              r_quo    <= w_a_mag;
              r_dvs    <= w_b_mag;
              r_sign_q <= w_sign_q;
              r_sign_r <= w_sign_r;
              r_cnt    <= CW'(STEPS);
            end
          end
        end
        S_CALC: begin
          if (!flush) begin
            r_rem <= w_rem_s;
            r_quo <= w_quo_s;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_q    <= r_sign_q ? -r_quo : r_quo;
            r_r    <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            r_done <= 1'b1;
          end
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign q     = r_q;
  assign r     = r_r;
  assign stall = (start & (r_state == S_IDLE)) | busy;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: default instance plus an ITERS_PER_CYCLE=2 instance.
// Expected fast-path latency follows DIV_FAST_PATH_EN when it is defined for the build.
module tb_div_seq_ctrl;

`ifdef DIV_FAST_PATH_EN
  localparam int FAST_LAT = 1;
`else
  localparam int FAST_LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign_flag;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        stall;

  logic        s2_start;
  logic        s2_sign;
  logic [31:0] s2_a;
  logic [31:0] s2_b;
  logic        s2_flush;
  logic        s2_busy;
  logic        s2_done;
  logic [31:0] s2_q;
  logic [31:0] s2_r;
  logic        s2_stall;

  int n_checks;
  int n_errors;

  div_seq_ctrl #(.WIDTH(32), .ITERS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .sign_flag(sign_flag), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .q(q), .r(r), .stall(stall)
  );

  div_seq_ctrl #(.WIDTH(32), .ITERS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .sign_flag(s2_sign), .a(s2_a), .b(s2_b),
    .flush(s2_flush), .busy(s2_busy), .done(s2_done), .q(s2_q), .r(s2_r), .stall(s2_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: start in cycle 0, scramble a/b after the sampling edge, count cycles to done.
  task automatic do_op(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       output int cyc, output logic [31:0] qo, output logic [31:0] ro,
                       output logic bs);
    @(negedge clk);
    sign_flag = s; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = -1; qo = '0; ro = '0; bs = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) bs = 1'b1;
      if (done) begin
        cyc = k; qo = q; ro = r;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sign_flag = 1'b0; a = '0; b = '0; flush = 1'b0;
    s2_start = 1'b0; s2_sign = 1'b0; s2_a = '0; s2_b = '0; s2_flush = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (q !== 32'h0) begin n_errors++; $display("FAIL reset_q got %h exp 0", q); end
    n_checks++; if (r !== 32'h0) begin n_errors++; $display("FAIL reset_r got %h exp 0", r); end
    n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int n_bad;
    n_bad = 0;
    @(negedge clk);
    sign_flag = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL u_cycle0 got stall=%b busy=%b exp stall=1 busy=0", stall, busy); end
    @(posedge clk);
    #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || stall !== 1'b1 || done !== 1'b0) n_bad++;
    end
    n_checks++; if (n_bad != 0) begin n_errors++; $display("FAIL u_busy_window got %0d bad cycles exp 0", n_bad); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin n_errors++; $display("FAIL u_done_c34 got done=%b busy=%b stall=%b exp 1 0 0", done, busy, stall); end
    n_checks++; if (q !== 32'd14) begin n_errors++; $display("FAIL u_q got %0d exp 14", q); end
    n_checks++; if (r !== 32'd2) begin n_errors++; $display("FAIL u_r got %0d exp 2", r); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || q !== 32'd14) begin n_errors++; $display("FAIL u_done_single got done=%b q=%0d exp 0 14", done, q); end
  endtask

  task automatic test_signed();
    int c; logic [31:0] qo, ro; logic bs;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, c, qo, ro, bs);
    n_checks++; if (c != 34) begin n_errors++; $display("FAIL s1_lat got %0d exp 34", c); end
    n_checks++; if (qo !== 32'hFFFF_FFFD || ro !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL s1_qr got %h/%h exp fffffffd/ffffffff", qo, ro); end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, c, qo, ro, bs);
    n_checks++; if (qo !== 32'hFFFF_FFFD || ro !== 32'd1) begin n_errors++; $display("FAIL s2_qr got %h/%h exp fffffffd/00000001", qo, ro); end
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, c, qo, ro, bs);
    n_checks++; if (qo !== 32'h7FFF_FFFC || ro !== 32'd1) begin n_errors++; $display("FAIL s3_unsigned_qr got %h/%h exp 7ffffffc/00000001", qo, ro); end
  endtask

  task automatic test_div_zero_overflow();
    int c; logic [31:0] qo, ro; logic bs;
    do_op(1'b0, 32'h1234_5678, 32'h0, c, qo, ro, bs);
    n_checks++; if (c != 1) begin n_errors++; $display("FAIL dz_lat got %0d exp 1", c); end
    n_checks++; if (qo !== 32'h0 || ro !== 32'h0) begin n_errors++; $display("FAIL dz_qr got %h/%h exp 0/0", qo, ro); end
    n_checks++; if (bs !== 1'b0) begin n_errors++; $display("FAIL dz_busy got %b exp 0", bs); end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, c, qo, ro, bs);
    n_checks++; if (c != FAST_LAT) begin n_errors++; $display("FAIL ovf_lat got %0d exp %0d", c, FAST_LAT); end
    n_checks++; if (qo !== 32'h8000_0000 || ro !== 32'h0) begin n_errors++; $display("FAIL ovf_qr got %h/%h exp 80000000/0", qo, ro); end
  endtask

  task automatic test_flush();
    int c; logic [31:0] qo, ro; logic bs; logic dseen;
    do_op(1'b0, 32'd100, 32'd7, c, qo, ro, bs);
    n_checks++; if (qo !== 32'd14) begin n_errors++; $display("FAIL fl_prior_q got %0d exp 14", qo); end
    @(negedge clk);
    sign_flag = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dseen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || dseen !== 1'b0) begin n_errors++; $display("FAIL fl_abort got busy=%b done=%b seen=%b exp 0 0 0", busy, done, dseen); end
    n_checks++; if (q !== 32'd14 || r !== 32'd2) begin n_errors++; $display("FAIL fl_hold got %0d/%0d exp 14/2", q, r); end
    do_op(1'b0, 32'd50, 32'd6, c, qo, ro, bs);
    n_checks++; if (c != 34 || qo !== 32'd8 || ro !== 32'd2) begin n_errors++; $display("FAIL fl_restart got lat=%0d %0d/%0d exp 34 8/2", c, qo, ro); end
    // flush in IDLE blocks both the b==0 fast path and a normal start
    @(negedge clk);
    a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    b = 32'd7; a = 32'd100;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL fl_idle got done=%b busy=%b exp 0 0", done, busy); end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sign_flag = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1; flush = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    n_checks++; if (q !== 32'h0 || r !== 32'h0) begin n_errors++; $display("FAIL rm_qr got %h/%h exp 0/0", q, r); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL rm_ctrl got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_back_to_back();
    int n_done, c1, c2; logic [31:0] q1, r1, q2, r2;
    n_done = 0; c1 = -1; c2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    @(negedge clk);
    sign_flag = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    a = 32'd9; b = 32'd3;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (done) begin
        if (n_done == 0) begin c1 = k; q1 = q; r1 = r; end
        else begin c2 = k; q2 = q; r2 = r; end
        n_done++;
        if (n_done == 1) begin
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
    end
    n_checks++; if (c1 != 34 || q1 !== 32'd14 || r1 !== 32'd2) begin n_errors++; $display("FAIL b2b_first got c=%0d %0d/%0d exp 34 14/2", c1, q1, r1); end
    n_checks++; if (c2 != 68 || q2 !== 32'd3 || r2 !== 32'd0) begin n_errors++; $display("FAIL b2b_second got c=%0d %0d/%0d exp 68 3/0", c2, q2, r2); end
    n_checks++; if (n_done != 2) begin n_errors++; $display("FAIL b2b_count got %0d exp 2", n_done); end
  endtask

  task automatic test_iters2();
    int c; logic [31:0] qo, ro;
    c = -1; qo = '0; ro = '0;
    @(negedge clk);
    s2_sign = 1'b0; s2_a = 32'd100; s2_b = 32'd7; s2_start = 1'b1;
    @(posedge clk);
    #1;
    s2_start = 1'b0; s2_a = '0; s2_b = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (s2_done) begin c = k; qo = s2_q; ro = s2_r; break; end
    end
    n_checks++; if (c != 18) begin n_errors++; $display("FAIL i2_lat got %0d exp 18", c); end
    n_checks++; if (qo !== 32'd14 || ro !== 32'd2) begin n_errors++; $display("FAIL i2_qr got %0d/%0d exp 14/2", qo, ro); end
  endtask

  task automatic test_fast_path();
    int c; logic [31:0] qo, ro; logic bs;
    do_op(1'b0, 32'd5, 32'd9, c, qo, ro, bs);
    n_checks++; if (c != FAST_LAT) begin n_errors++; $display("FAIL fp1_lat got %0d exp %0d", c, FAST_LAT); end
    n_checks++; if (qo !== 32'd0 || ro !== 32'd5) begin n_errors++; $display("FAIL fp1_qr got %0d/%0d exp 0/5", qo, ro); end
    do_op(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, c, qo, ro, bs);
    n_checks++; if (c != FAST_LAT) begin n_errors++; $display("FAIL fp2_lat got %0d exp %0d", c, FAST_LAT); end
    n_checks++; if (qo !== 32'd16 || ro !== 32'd0) begin n_errors++; $display("FAIL fp2_qr got %0d/%0d exp 16/0", qo, ro); end
    do_op(1'b1, 32'hFFFF_FFFB, 32'd9, c, qo, ro, bs);
    n_checks++; if (qo !== 32'd0 || ro !== 32'hFFFF_FFFB) begin n_errors++; $display("FAIL fp3_qr got %h/%h exp 0/fffffffb", qo, ro); end
    do_op(1'b1, 32'hFFFF_FFF0, 32'd1, c, qo, ro, bs);
    n_checks++; if (qo !== 32'hFFFF_FFF0 || ro !== 32'd0) begin n_errors++; $display("FAIL fp4_qr got %h/%h exp fffffff0/0", qo, ro); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero_overflow();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_iters2();
    test_fast_path();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the CPU's divide instructions (DIV/DIVU).
- Replaces single-cycle combinational division with an iterative restoring divider, using a start/busy/done handshake.
- Raises stall to the pipeline while a divide is in flight and delivers quotient/remainder for the HI/LO write.
- Divide-by-zero semantics match the existing datapath: Q=0, R=0.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ITERS_PER_CYCLE, 1, restoring iterations per clock. Legal values 1, 2, 4; must divide WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- sign_flag  in  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- a  in  WIDTH  dividend; captured with start.
- b  in  WIDTH  divisor; captured with start.
- flush  in  1  abort the in-flight divide (exception or pipeline flush).
- busy  out  1  divide in progress (CALC or FIX).
- done  out  1  one-cycle pulse; q/r valid from this cycle on.
- q  out  WIDTH  quotient, registered, held until next done.
- r  out  WIDTH  remainder, registered, held until next done.
- stall  out  1  combinational: (start & IDLE) | busy.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, q=0, r=0; internal registers cleared. rst has priority over flush and start, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE -> CALC: start=1 and b!=0.
  - Latch |a|, |b| (two's-complement magnitudes when sign_flag=1, raw values otherwise).
  - Latch sign_q = sign_flag & (a[MSB]^b[MSB]) and sign_r = sign_flag & a[MSB].
  - Clear partial remainder; load iteration counter = WIDTH/ITERS_PER_CYCLE.
- IDLE with start=1 and b==0: no state change. On that edge q=0, r=0, done=1 the next cycle, busy never asserts.
- CALC: each edge performs ITERS_PER_CYCLE restoring steps.
  - Each step: shift remainder left, bringing in the dividend MSB. If remainder>=|b|, subtract and set the quotient bit to 1; else set it to 0.
  - Remainder register is WIDTH+1 bits.
  - Counter decrements each edge; when the count reaches 0 -> FIX.
- FIX: one edge.
  - q = sign_q ? -Qmag : Qmag; r = sign_r ? -Rmag : Rmag.
  - done=1 for the following cycle; state -> IDLE.
- Latency: with start sampled at edge E0, done is high during the cycle after edge E(WIDTH/ITERS_PER_CYCLE + 1).
  - Defaults: done is high 34 cycles after start.
  - busy is high from E0 until the done cycle; busy=0 during the done cycle.
- Signed semantics: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): q=0x80000000, r=0.
- start while busy: ignored; no queuing.
- start in the done cycle: accepted, because the state is IDLE. This gives back-to-back operation.
- flush:
  - In CALC or FIX: next state IDLE, no done pulse, q/r keep their previous values.
  - In IDLE: blocks a simultaneous start, including the b==0 fast path.
- done is never asserted for two consecutive cycles from a single request.
- a and b may change freely after start is sampled.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: in IDLE with start=1, b!=0 and no flush, two cases complete in one edge with no CALC/FIX. done is high the next cycle and busy never asserts.
  - Case 1: |a|<|b|. Result q=0, r=a.
  - Case 2: |b|==1. Result q = a, or -a when sign_q; r=0. Signed overflow (0x80000000 / 0xFFFFFFFF) still gives q=0x80000000, r=0.
- Not defined: every divide with b!=0 takes the full iterative latency.
- Results are bit-identical in both builds.

Test Plan:
- Unsigned: sign_flag=0, a=100, b=7, start one cycle -> done at cycle 34 with q=14, r=2; busy high for cycles 1..33; stall high for cycles 0..33.
- Signed: sign_flag=1, a=0xFFFFFFF9 (-7), b=2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Also a=7, b=0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- Divide-by-zero and overflow:
  - a=0x12345678, b=0 -> done at cycle 1, q=0, r=0, busy never high.
  - sign_flag=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
- Flush and reset mid-operation:
  - flush at cycle 10 of a divide -> no done pulse; q/r keep the prior result; a new start at cycle 11 completes normally.
  - rst at cycle 20 -> q=0, r=0, busy=0 on the next cycle.
- Handshake:
  - A second start held high during busy is ignored.
  - start asserted in the done cycle -> second result arrives 34 cycles later.
  - ITERS_PER_CYCLE=2 build: 100/7 completes at cycle 18.
- DIV_FAST_PATH_EN defined:
  - a=5, b=9 -> done at cycle 1, q=0, r=5.
  - sign_flag=1, a=0xFFFFFFF0, b=0xFFFFFFFF -> done at cycle 1, q=16, r=0.
  - With the macro undefined, the same cases complete at cycle 34 with identical values.
